// File: rtl/m21_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux channel: registered grants/select,
// per-tenure burst limit, and a VALID/RDY handshake toward one consumer.
module m21_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             RDY,
    output logic             GNT0,
    output logic             GNT1,
    output logic             S0,
    output logic [WIDTH-1:0] Y,
    output logic             VALID,
    output logic             BUSY,
    output logic [1:0]       dbg_state
);

    // Handshake: a word moves when VALID & RDY are both high at a rising CLK
    // edge; VALID never waits on RDY, and RDY may change freely.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             xfer;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign xfer = VALID & RDY;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the channel last wins.
                if (REQ0 && REQ1) state_d = last_q ? G0 : G1;
                else if (REQ0)    state_d = G0;
                else if (REQ1)    state_d = G1;
            end
            G0: begin
                if (!REQ0)                                  state_d = REQ1 ? G1 : IDLE;
                else if (REQ1 && xfer && cnt_q == HOLD_LAST) state_d = G1;
            end
            G1: begin
                if (!REQ1)                                  state_d = REQ0 ? G0 : IDLE;
                else if (REQ0 && xfer && cnt_q == HOLD_LAST) state_d = G0;
            end
            default: state_d = IDLE;
        endcase

        cnt_d  = cnt_q;
        last_d = last_q;
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == G0) last_d = 1'b0;
            if (state_d == G1) last_d = 1'b1;
        end else if (xfer && cnt_q != HOLD_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        GNT0      = (state_q == G0);
        GNT1      = (state_q == G1);
        S0        = GNT1;
        BUSY      = (state_q != IDLE);
        VALID     = (GNT0 & REQ0) | (GNT1 & REQ1);
        Y         = S0 ? I1 : I0;
        dbg_state = state_q;
    end

endmodule
